// File: rtl/pwm_preconditioner.sv
// Sweeps every transducer once per DEPTH+3 clocks, turning (duty, phase, cycle) into
// absolute rise/fall times; results land in a shadow bank committed atomically.
module pwm_preconditioner #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 249
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        UPDATE_EN,
  input  logic [DEPTH-1:0][WIDTH-1:0] CYCLE,
  input  logic [DEPTH-1:0][WIDTH-1:0] DUTY,
  input  logic [DEPTH-1:0][WIDTH-1:0] PHASE,
  output logic [DEPTH-1:0][WIDTH-1:0] RISE,
  output logic [DEPTH-1:0][WIDTH-1:0] FALL,
  output logic                        DONE
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_COMMIT} state_t;

  state_t                      r_state;
  logic [IW-1:0]               r_idx;
  logic                        r_drain;
  logic                        r_v1;
  logic [IW-1:0]               r_idx1;
  logic [WIDTH-1:0]            r_d1;
  logic [WIDTH-1:0]            r_p1;
  logic [WIDTH-1:0]            r_c1;
  logic                        r_full1;
  logic [DEPTH-1:0][WIDTH-1:0] r_sh_rise;
  logic [DEPTH-1:0][WIDTH-1:0] r_sh_fall;

  // Stage 1 operands: the selected transducer's inputs, sampled live
  logic [WIDTH-1:0] w_cyc;
  logic [WIDTH-1:0] w_duty;
  logic [WIDTH-1:0] w_phase;
  logic [WIDTH-1:0] w_d;
  logic [WIDTH-1:0] w_p;
  logic             w_full;

  assign w_cyc   = CYCLE[r_idx];
  assign w_duty  = DUTY[r_idx];
  assign w_phase = PHASE[r_idx];
  assign w_d     = (w_duty < w_cyc) ? w_duty : w_cyc;
  assign w_p     = (w_phase < w_cyc) ? w_phase : '0;
  assign w_full  = (w_d == w_cyc) && (w_cyc != '0);

  // Stage 2: one extra bit so the wrap checks see true sign / overflow
  logic [WIDTH:0]   w_dl;
  logic [WIDTH:0]   w_dr;
  logic [WIDTH:0]   w_rsum;
  logic [WIDTH:0]   w_rwrap;
  logic [WIDTH:0]   w_fsum;
  logic [WIDTH:0]   w_fwrap;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;

  assign w_dl    = {1'b0, r_d1} >> 1;
  assign w_dr    = ({1'b0, r_d1} + (WIDTH+1)'(1)) >> 1;
  assign w_rsum  = {1'b0, r_p1} - w_dl;
  assign w_rwrap = w_rsum[WIDTH] ? (w_rsum + {1'b0, r_c1}) : w_rsum;
  assign w_fsum  = {1'b0, r_p1} + w_dr;
  assign w_fwrap = (w_fsum >= {1'b0, r_c1}) ? (w_fsum - {1'b0, r_c1}) : w_fsum;
  assign w_rise  = r_full1 ? '0 : w_rwrap[WIDTH-1:0];
  assign w_fall  = r_full1 ? r_c1 : w_fwrap[WIDTH-1:0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_RUN;
      r_idx     <= '0;
      r_drain   <= 1'b0;
      r_v1      <= 1'b0;
      r_idx1    <= '0;
      r_d1      <= '0;
      r_p1      <= '0;
      r_c1      <= '0;
      r_full1   <= 1'b0;
      r_sh_rise <= '0;
      r_sh_fall <= '0;
      RISE      <= '0;
      FALL      <= '0;
      DONE      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      r_v1 <= 1'b0;
      if (r_v1) begin
        r_sh_rise[r_idx1] <= w_rise;
        r_sh_fall[r_idx1] <= w_fall;
      end
      case (r_state)
        S_RUN: begin
          r_v1    <= 1'b1;
          r_idx1  <= r_idx;
          r_d1    <= w_d;
          r_p1    <= w_p;
          r_c1    <= w_cyc;
          r_full1 <= w_full;
          if (r_idx == IW'(DEPTH-1)) begin
            r_state <= S_DRAIN;
            r_drain <= 1'b0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DRAIN: begin
          r_drain <= ~r_drain;
          if (r_drain) r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          // Skipped commits leave the shadow to be overwritten by the next sweep
          if (UPDATE_EN) begin
            RISE <= r_sh_rise;
            FALL <= r_sh_fall;
            DONE <= 1'b1;
          end
          r_idx   <= '0;
          r_state <= S_RUN;
        end
        default: begin
          r_idx   <= '0;
          r_state <= S_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_preconditioner.sv
// Randomized and directed checks of pwm_preconditioner (DEPTH=4) against an
// arithmetic reference model of the rise/fall rules and the commit timing.
module tb_pwm_preconditioner;

  localparam int W = 13;
  localparam int N = 4;

  logic              CLK;
  logic              RST;
  logic              UPDATE_EN;
  logic [N-1:0][W-1:0] CYCLE;
  logic [N-1:0][W-1:0] DUTY;
  logic [N-1:0][W-1:0] PHASE;
  logic [N-1:0][W-1:0] RISE;
  logic [N-1:0][W-1:0] FALL;
  logic              DONE;

  pwm_preconditioner #(.WIDTH(W), .DEPTH(N)) dut (
    .CLK(CLK), .RST(RST), .UPDATE_EN(UPDATE_EN),
    .CYCLE(CYCLE), .DUTY(DUTY), .PHASE(PHASE),
    .RISE(RISE), .FALL(FALL), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec  = 0;
  int n_miss = 0;

  int cyc_in[N];
  int duty_in[N];
  int phase_in[N];
  int exp_r[N];
  int exp_f[N];
  int pend_r[N];
  int pend_f[N];

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void ref_calc(input int c, input int d, input int p,
                                   output int r, output int f);
    int dd, pp;
    dd = (d < c) ? d : c;
    pp = (p < c) ? p : 0;
    if (c != 0 && dd == c) begin
      r = 0;
      f = c;
    end else begin
      r = pp - dd / 2;
      if (r < 0) r += c;
      f = pp + (dd + 1) / 2;
      if (f >= c) f -= c;
    end
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      CYCLE[i] = cyc_in[i][W-1:0];
      DUTY[i]  = duty_in[i][W-1:0];
      PHASE[i] = phase_in[i][W-1:0];
    end
  endtask

  task automatic set_uniform(input int c, input int d, input int p);
    for (int i = 0; i < N; i++) begin
      cyc_in[i] = c; duty_in[i] = d; phase_in[i] = p;
    end
    drive_inputs();
  endtask

  task automatic model_pending();
    for (int i = 0; i < N; i++) ref_calc(cyc_in[i], duty_in[i], phase_in[i], pend_r[i], pend_f[i]);
  endtask

  task automatic take_pending();
    for (int i = 0; i < N; i++) begin
      exp_r[i] = pend_r[i]; exp_f[i] = pend_f[i];
    end
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < N; i++) begin
      int sel;
      cyc_in[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 8191));
      sel = int'($urandom_range(0, 3));
      duty_in[i]  = (sel == 0) ? cyc_in[i] : (sel == 1) ? 0 : int'($urandom_range(0, 8191));
      phase_in[i] = int'($urandom_range(0, 8191));
    end
    drive_inputs();
  endtask

  task automatic check_lanes(input string tag);
    for (int i = 0; i < N; i++) begin
      check_val({tag, "_rise"}, int'(RISE[i]), exp_r[i]);
      check_val({tag, "_fall"}, int'(FALL[i]), exp_f[i]);
    end
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < budget) begin
      @(posedge CLK); #1;
      cycles++;
      if (DONE) seen = 1'b1;
    end
  endtask

  // Test-plan vectors at CYCLE=4096 with hand-derived results
  int dv_d[7] = '{2048, 2048, 3,    0,   1,   5000, 2};
  int dv_p[7] = '{1024, 0,    4095, 100, 100, 100,  5000};
  int dv_r[7] = '{0,    3072, 4094, 100, 100, 0,    4095};
  int dv_f[7] = '{2048, 1024, 1,    100, 101, 4096, 1};

  initial begin
    int  cyc;
    bit  seen;
    int  dcount;
    int  last_done;
    bit  en;

    RST = 1'b1;
    UPDATE_EN = 1'b1;
    set_uniform(4096, dv_d[0], dv_p[0]);
    repeat (3) @(posedge CLK);
    #1;
    for (int i = 0; i < N; i++) begin
      check_val("rst_rise", int'(RISE[i]), 0);
      check_val("rst_fall", int'(FALL[i]), 0);
    end
    check_val("rst_done", int'(DONE), 0);

    @(negedge CLK) RST = 1'b0;
    wait_done(20, cyc, seen);
    check_val("first_done_seen", int'(seen), 1);
    check_val("first_done_lat", cyc, 7);
    for (int i = 0; i < N; i++) begin
      exp_r[i] = dv_r[0]; exp_f[i] = dv_f[0];
    end
    check_lanes("centred");

    for (int k = 1; k < 7; k++) begin
      set_uniform(4096, dv_d[k], dv_p[k]);
      for (int i = 0; i < N; i++) begin
        exp_r[i] = dv_r[k]; exp_f[i] = dv_f[k];
      end
      wait_done(10, cyc, seen);
      check_val("dir_done_seen", int'(seen), 1);
      check_val("dir_period", cyc, 7);
      check_lanes($sformatf("dir%0d", k));
    end

    // Per-lane independence, including a zero-period lane
    cyc_in = '{4096, 2000, 0, 8191};
    for (int i = 0; i < N; i++) begin
      duty_in[i] = 1000; phase_in[i] = 1000;
    end
    drive_inputs();
    model_pending();
    take_pending();
    check_val("lane2_model_rise", exp_r[2], 0);
    for (int s = 0; s < 10; s++) begin
      wait_done(10, cyc, seen);
      check_val("lane_done_seen", int'(seen), 1);
      check_val("lane_period", cyc, 7);
      check_lanes("lane");
    end

    // Commit gating: outputs frozen while UPDATE_EN is low
    UPDATE_EN = 1'b0;
    dcount = 0;
    for (int s = 0; s < 3; s++) begin
      rand_inputs();
      repeat (7) begin
        @(posedge CLK); #1;
        if (DONE) dcount++;
      end
      check_lanes("gate_frozen");
    end
    rand_inputs();
    model_pending();
    repeat (14) begin
      @(posedge CLK); #1;
      if (DONE) dcount++;
    end
    check_val("gate_no_done", dcount, 0);
    check_lanes("gate_frozen2");
    UPDATE_EN = 1'b1;
    wait_done(7, cyc, seen);
    check_val("gate_done_seen", int'(seen), 1);
    take_pending();
    check_lanes("gate_commit");

    // Reset in the middle of a sweep
    repeat (2) begin
      @(posedge CLK); #1;
    end
    RST = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      exp_r[i] = 0; exp_f[i] = 0;
    end
    check_lanes("midrst");
    check_val("midrst_done", int'(DONE), 0);
    set_uniform(4096, 1000, 3000);
    model_pending();
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST = 1'b0;
    wait_done(20, cyc, seen);
    check_val("midrst_done_seen", int'(seen), 1);
    check_val("midrst_lat", cyc, 7);
    take_pending();
    check_lanes("midrst_commit");

    // Random sweeps, each aligned to the commit boundary
    for (int n = 0; n < 40; n++) begin
      rand_inputs();
      en = ($urandom_range(0, 3) != 0);
      UPDATE_EN = en;
      model_pending();
      dcount = 0;
      last_done = 0;
      for (int j = 0; j < 7; j++) begin
        @(posedge CLK); #1;
        if (DONE) dcount++;
        if (j == 6) last_done = int'(DONE);
      end
      check_val("rnd_done_cnt", dcount, int'(en));
      check_val("rnd_done_pos", last_done, int'(en));
      if (en) take_pending();
      check_lanes("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/pwm_preconditioner.md
Name: pwm_preconditioner

Overview:
- Sits between the silencer output (DUTY_S/PHASE_S) and the pwm generator.
- Continuously sweeps all DEPTH transducers, one per clock, and converts each (duty, phase, cycle) triple into absolute rise/fall times within the ultrasound period.
- Results are staged in a shadow bank and committed atomically, so the pwm block never sees a half-updated transducer set.

Parameters:
- WIDTH, 13, bit width of duty/phase/cycle/rise/fall
- DEPTH, 249, number of transducers

Ports:
- CLK  input  1  clk_l domain clock
- RST  input  1  reset, asynchronous, active-high
- UPDATE_EN  input  1  permits commit of a finished sweep
- CYCLE  input  WIDTH x DEPTH  ultrasound period per transducer
- DUTY  input  WIDTH x DEPTH  silenced duty
- PHASE  input  WIDTH x DEPTH  silenced phase
- RISE  output  WIDTH x DEPTH  rise time per transducer
- FALL  output  WIDTH x DEPTH  fall time per transducer
- DONE  output  1  one-cycle pulse on commit

Behaviour:
- Clock and reset: one clock (CLK); reset RST is asynchronous, active-high.
- Reset values: RISE=0, FALL=0, DONE=0, shadow bank=0, idx=0, state=RUN.
- FSM sequence: RUN -> DRAIN -> COMMIT -> RUN, free-running.
  - RUN: idx steps 0..DEPTH-1, one transducer per clock; leaves RUN after idx=DEPTH-1.
  - DRAIN: 2 clocks, flushes the 2-stage pipeline.
  - COMMIT: 1 clock, then idx=0 and back to RUN.
- Sweep period: DEPTH+3 clocks.
- Pipeline stage 1 (registered): samples DUTY[idx], PHASE[idx], CYCLE[idx] live (no input latching), then:
  - d = min(DUTY, CYCLE).
  - p = PHASE if PHASE < CYCLE, else 0.
  - full = (d == CYCLE) and CYCLE != 0.
- Pipeline stage 2 (registered), computes and writes shadow[idx-2]:
  - full: rise=0, fall=CYCLE.
  - otherwise, with dl = d>>1, dr = (d+1)>>1:
    - rise = p - dl, plus CYCLE if negative.
    - fall = p + dr, minus CYCLE if >= CYCLE.
  - Use WIDTH+1-bit intermediates; results always < CYCLE except the full case.
- d==0 gives rise=fall=p, meaning no pulse; pwm treats rise==fall as off.
- CYCLE==0 for a transducer: rise=fall=0.
- COMMIT with UPDATE_EN=1: all RISE/FALL <= shadow on the same edge; DONE=1 for exactly the following cycle, coincident with the first cycle the new values are visible.
- COMMIT with UPDATE_EN=0: outputs held, DONE stays 0, shadow overwritten by the next sweep.
- First DONE arrives DEPTH+3 clock edges after RST deasserts, given UPDATE_EN=1.
- Inputs changing mid-sweep: each transducer uses the value present at its own sample cycle; no cross-sweep coherence is guaranteed beyond that.
- RST mid-sweep: immediate clear of outputs, shadow and FSM; the partial sweep is discarded, no DONE.
- No back-pressure; the pwm block samples RISE/FALL at any time and sees only committed banks.

Test Plan:
- Bench uses DEPTH=4, WIDTH=13, CYCLE=4096 unless stated.
- Centred duty: DUTY=2048, PHASE=1024 -> RISE=0, FALL=2048 after first DONE (7 clocks after reset release).
- Rise wrap and odd duty:
  - PHASE=0, DUTY=2048 -> RISE=3072, FALL=1024.
  - PHASE=4095, DUTY=3 -> RISE=4094, FALL=1.
- Edge duties:
  - DUTY=0, PHASE=100 -> RISE=FALL=100.
  - DUTY=1, PHASE=100 -> RISE=100, FALL=101.
  - DUTY=5000 (clamped full) -> RISE=0, FALL=4096.
  - PHASE=5000, DUTY=2 -> RISE=4095, FALL=1.
- Commit gating: UPDATE_EN=0 for 3 sweeps while inputs change -> no DONE, outputs frozen; raise UPDATE_EN -> next DONE within 7 clocks, new values visible in the same cycle as DONE.
- Reset mid-sweep: assert RST at idx=2 -> RISE/FALL/DONE=0 asynchronously; after release the first DONE is exactly 7 clocks later.
- Per-transducer independence: distinct CYCLE {4096, 2000, 0, 8191} with DUTY=PHASE=1000 -> results match the formula per lane, lane 2 = 0/0; DONE period stays 7 clocks over 10 sweeps.
